// File: rtl/byte_packer.sv
// byte_packer: packs a captured byte stream little-endian into LANES-byte words.
// Latency: 1 cycle from the completing byte (or flush) to out_valid.
// Backpressure: the input cannot be stalled; when the output buffer is full,
// completed words are dropped and the sticky overflow flag is raised.
//
// Ports:
//   clk, rst                 sole clock; asynchronous active-high reset
//   in_valid, in_data        byte strobe and value from the capturing sink
//   flush                    emit the current partial word (with in_valid: byte first)
//   out_valid/out_ready      handshake for the head of the output buffer
//   out_data, out_keep       head word (first byte in [7:0]) and per-byte valid mask
//   overflow                 sticky: a completed word was discarded
//   word_count               words handed off, wraps at 2^16
//   seq_err_count            increment-sequence violations, saturating
module byte_packer #(
    parameter int LANES      = 4,
    parameter int OBUF_DEPTH = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    input  logic [7:0]           in_data,
    input  logic                 flush,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [8*LANES-1:0]   out_data,
    output logic [LANES-1:0]     out_keep,
    output logic                 overflow,
    output logic [15:0]          word_count,
    output logic [15:0]          seq_err_count
);

    localparam int LW = $clog2(LANES);
    localparam int PW = (OBUF_DEPTH > 1) ? $clog2(OBUF_DEPTH) : 1;
    localparam int CW = $clog2(OBUF_DEPTH + 1);

    // ------------------------------------------------------------------
    // Assembly FSM
    // ------------------------------------------------------------------
    typedef enum logic {
        S_EMPTY = 1'b0,
        S_FILL  = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [LW-1:0]      lane_q, lane_d;
    logic [8*LANES-1:0] word_q, word_d;

    // Word as it looks once this cycle's byte (if any) has been written.
    logic [8*LANES-1:0] merged_dat;
    logic [LW:0]        fill_n;
    logic               last_lane;
    logic               word_done;
    logic [LANES-1:0]   done_keep;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_EMPTY;
            lane_q  <= '0;
            word_q  <= '0;
        end else begin
            state_q <= state_d;
            lane_q  <= lane_d;
            word_q  <= word_d;
        end
    end

    // Next-state logic. The assembly register is cleared whenever a word
    // leaves it, so lanes not written before a flush read back as zero.
    always_comb begin
        state_d = state_q;
        lane_d  = lane_q;
        word_d  = word_q;
        case (state_q)
            S_EMPTY: begin
                if (word_done) begin
                    state_d = S_EMPTY;
                    lane_d  = '0;
                    word_d  = '0;
                end else if (in_valid) begin
                    state_d = S_FILL;
                    lane_d  = lane_q + LW'(1);
                    word_d  = merged_dat;
                end
            end
            S_FILL: begin
                if (word_done) begin
                    state_d = S_EMPTY;
                    lane_d  = '0;
                    word_d  = '0;
                end else if (in_valid) begin
                    lane_d = lane_q + LW'(1);
                    word_d = merged_dat;
                end
            end
            default: begin
                state_d = S_EMPTY;
                lane_d  = '0;
                word_d  = '0;
            end
        endcase
    end

    // Output logic: word completion and the word/keep handed to the buffer.
    // A byte landing in the last lane completes the word on its own, so a
    // simultaneous flush cannot produce a second (empty) word.
    always_comb begin
        merged_dat = word_q;
        if (in_valid) begin
            merged_dat[{lane_q, 3'b000} +: 8] = in_data;
        end
        fill_n    = {1'b0, lane_q} + {{LW{1'b0}}, in_valid};
        last_lane = in_valid && (lane_q == LW'(LANES - 1));
        word_done = last_lane || (flush && ((state_q == S_FILL) || in_valid));
        for (int i = 0; i < LANES; i++) begin
            done_keep[i] = ((LW + 1)'(i) < fill_n);
        end
    end

    // ------------------------------------------------------------------
    // Output buffer: circular FIFO of {data, keep}
    // ------------------------------------------------------------------
    logic [8*LANES-1:0] obuf_dat_q  [OBUF_DEPTH];
    logic [LANES-1:0]   obuf_keep_q [OBUF_DEPTH];
    logic [PW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]      cnt_q, cnt_d;

    logic obuf_pop;
    logic obuf_push;
    logic obuf_drop;

    // A pop in the same cycle frees the slot the new word needs.
    assign obuf_pop  = (cnt_q != '0) && out_ready;
    assign obuf_push = word_done && ((cnt_q != CW'(OBUF_DEPTH)) || obuf_pop);
    assign obuf_drop = word_done && !obuf_push;

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        cnt_d    = cnt_q;
        if (obuf_pop) begin
            rd_ptr_d = (rd_ptr_q == PW'(OBUF_DEPTH - 1)) ? '0 : rd_ptr_q + PW'(1);
        end
        if (obuf_push) begin
            wr_ptr_d = (wr_ptr_q == PW'(OBUF_DEPTH - 1)) ? '0 : wr_ptr_q + PW'(1);
        end
        case ({obuf_push, obuf_pop})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
            for (int i = 0; i < OBUF_DEPTH; i++) begin
                obuf_dat_q[i]  <= '0;
                obuf_keep_q[i] <= '0;
            end
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            cnt_q    <= cnt_d;
            if (obuf_push) begin
                obuf_dat_q[wr_ptr_q]  <= merged_dat;
                obuf_keep_q[wr_ptr_q] <= done_keep;
            end
        end
    end

    // Head entry is presented only while valid so idle outputs read as zero.
    assign out_valid = (cnt_q != '0);
    assign out_data  = out_valid ? obuf_dat_q[rd_ptr_q]  : '0;
    assign out_keep  = out_valid ? obuf_keep_q[rd_ptr_q] : '0;

    // ------------------------------------------------------------------
    // Status: overflow, handed-off words, sequence errors
    // ------------------------------------------------------------------
    logic        overflow_q, overflow_d;
    logic [15:0] word_count_q, word_count_d;
    logic [15:0] seq_err_q, seq_err_d;
    logic [7:0]  ref_q, ref_d;
    logic        ref_vld_q, ref_vld_d;

    always_comb begin
        overflow_d   = overflow_q | obuf_drop;
        word_count_d = obuf_pop ? word_count_q + 16'd1 : word_count_q;
        seq_err_d    = seq_err_q;
        ref_d        = ref_q;
        ref_vld_d    = ref_vld_q;
        if (in_valid) begin
            // 8-bit add wraps, so FF -> 00 is a legal increment.
            if (ref_vld_q && (in_data != ref_q + 8'd1) && (seq_err_q != 16'hFFFF)) begin
                seq_err_d = seq_err_q + 16'd1;
            end
            // Always resync to the received byte so one glitch counts once.
            ref_d     = in_data;
            ref_vld_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow_q   <= 1'b0;
            word_count_q <= '0;
            seq_err_q    <= '0;
            ref_q        <= '0;
            ref_vld_q    <= 1'b0;
        end else begin
            overflow_q   <= overflow_d;
            word_count_q <= word_count_d;
            seq_err_q    <= seq_err_d;
            ref_q        <= ref_d;
            ref_vld_q    <= ref_vld_d;
        end
    end

    assign overflow      = overflow_q;
    assign word_count    = word_count_q;
    assign seq_err_count = seq_err_q;

endmodule

// File: tb/tb_byte_packer.sv
// tb_byte_packer: directed stimulus against a queue-based reference model,
// checked every cycle on the falling edge, plus literal expectations.
module tb_byte_packer;

    localparam int LANES = 4;
    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [3:0]  out_keep;
    logic        overflow;
    logic [15:0] word_count;
    logic [15:0] seq_err_count;

    byte_packer #(.LANES(LANES), .OBUF_DEPTH(DEPTH)) dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_data       (in_data),
        .flush         (flush),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_data      (out_data),
        .out_keep      (out_keep),
        .overflow      (overflow),
        .word_count    (word_count),
        .seq_err_count (seq_err_count)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [31:0] dat;
        logic [3:0]  keep;
    } word_t;

    word_t      m_q[$];
    logic [7:0] m_asm[LANES];
    int         m_n;
    bit         m_ovf;
    int         m_wc;
    int         m_sec;
    bit         m_ref_vld;
    logic [7:0] m_ref;

    function automatic void model_clear();
        m_q.delete();
        m_n       = 0;
        m_ovf     = 1'b0;
        m_wc      = 0;
        m_sec     = 0;
        m_ref_vld = 1'b0;
        m_ref     = 8'h00;
    endfunction

    function automatic void model_step(bit v, logic [7:0] d, bit f, bit rdy);
        word_t w;
        bit    done;
        if (m_q.size() > 0 && rdy) begin
            void'(m_q.pop_front());
            m_wc = (m_wc + 1) % 65536;
        end
        if (v) begin
            if (m_ref_vld && d != 8'((int'(m_ref) + 1) % 256) && m_sec < 65535) m_sec++;
            m_ref     = d;
            m_ref_vld = 1'b1;
            m_asm[m_n] = d;
            m_n++;
        end
        done = (m_n == LANES) || (f && m_n > 0);
        if (done) begin
            w.dat = 32'h0;
            for (int i = 0; i < m_n; i++) w.dat = w.dat | (32'(m_asm[i]) << (8 * i));
            w.keep = 4'((1 << m_n) - 1);
            if (m_q.size() < DEPTH) m_q.push_back(w);
            else m_ovf = 1'b1;
            m_n = 0;
        end
    endfunction

    // ---------------- per-cycle compare ----------------
    initial begin
        forever begin
            @(negedge clk);
            if (chk_en && !rst) begin
                chk("out_valid", 32'(out_valid), 32'(m_q.size() != 0));
                if (m_q.size() != 0) begin
                    chk("out_data", out_data, m_q[0].dat);
                    chk("out_keep", 32'(out_keep), 32'(m_q[0].keep));
                end
                chk("overflow", 32'(overflow), 32'(m_ovf));
                chk("word_count", 32'(word_count), 32'(m_wc));
                chk("seq_err_count", 32'(seq_err_count), 32'(m_sec));
            end
        end
    end

    // ---------------- driver helpers ----------------
    task automatic tick(input bit v, input logic [7:0] d, input bit f);
        bit rdy;
        in_valid = v;
        in_data  = d;
        flush    = f;
        @(posedge clk);
        rdy = out_ready;
        model_step(v, d, f, rdy);
        @(negedge clk);
        in_valid = 1'b0;
        flush    = 1'b0;
    endtask

    // Called on a falling edge; reset is asserted/released off the edges.
    task automatic apply_reset();
        #1;
        rst = 1'b1;
        model_clear();
        repeat (2) @(negedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_valid"}, 32'(out_valid), 32'h0);
        chk({tag, "_data"}, out_data, 32'h0);
        chk({tag, "_keep"}, 32'(out_keep), 32'h0);
        chk({tag, "_ovf"}, 32'(overflow), 32'h0);
        chk({tag, "_wc"}, 32'(word_count), 32'h0);
        chk({tag, "_sec"}, 32'(seq_err_count), 32'h0);
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        flush     = 1'b0;
        out_ready = 1'b1;
        model_clear();
        repeat (2) @(negedge clk);
        #1;
        rst = 1'b0;
        chk_zero_outputs("reset");
        chk_en = 1'b1;

        // Packing: 0x01..0x08 with out_ready high.
        @(negedge clk);
        for (int i = 1; i <= 8; i++) begin
            tick(1'b1, 8'(i), 1'b0);
            if (i == 4) begin
                chk("pack_w0", out_data, 32'h04030201);
                chk("pack_k0", 32'(out_keep), 32'hF);
            end
            if (i == 8) chk("pack_w1", out_data, 32'h08070605);
        end
        tick(1'b0, 8'h00, 1'b0);
        chk("pack_wc", 32'(word_count), 32'd2);
        chk("pack_sec", 32'(seq_err_count), 32'd0);

        // Flush a partial word, then a flush with nothing pending.
        apply_reset();
        tick(1'b1, 8'h10, 1'b0);
        tick(1'b1, 8'h11, 1'b0);
        tick(1'b1, 8'h12, 1'b0);
        tick(1'b0, 8'h00, 1'b1);
        chk("flush_w", out_data, 32'h00121110);
        chk("flush_k", 32'(out_keep), 32'h7);
        tick(1'b0, 8'h00, 1'b1);
        chk("flush_empty_valid", 32'(out_valid), 32'h0);
        chk("flush_empty_wc", 32'(word_count), 32'd1);

        // Flush coinciding with the byte that fills the word.
        apply_reset();
        tick(1'b1, 8'h20, 1'b0);
        tick(1'b1, 8'h21, 1'b0);
        tick(1'b1, 8'h22, 1'b0);
        tick(1'b1, 8'h23, 1'b1);
        chk("flush_last_w", out_data, 32'h23222120);
        chk("flush_last_k", 32'(out_keep), 32'hF);
        tick(1'b0, 8'h00, 1'b0);
        chk("flush_last_valid", 32'(out_valid), 32'h0);
        chk("flush_last_wc", 32'(word_count), 32'd1);

        // Overflow under backpressure.
        apply_reset();
        out_ready = 1'b0;
        for (int i = 1; i <= 12; i++) tick(1'b1, 8'(i), 1'b0);
        chk("ovf_flag", 32'(overflow), 32'h1);
        chk("ovf_head", out_data, 32'h04030201);
        out_ready = 1'b1;
        tick(1'b0, 8'h00, 1'b0);
        chk("ovf_second", out_data, 32'h08070605);
        tick(1'b0, 8'h00, 1'b0);
        chk("ovf_wc", 32'(word_count), 32'd2);
        chk("ovf_sticky", 32'(overflow), 32'h1);

        // Sequence check with an FF -> 00 wrap and one glitch.
        apply_reset();
        tick(1'b1, 8'hFE, 1'b0);
        tick(1'b1, 8'hFF, 1'b0);
        tick(1'b1, 8'h00, 1'b0);
        tick(1'b1, 8'h05, 1'b0);
        chk("seq_word", out_data, 32'h0500FFFE);
        tick(1'b1, 8'h06, 1'b0);
        tick(1'b0, 8'h00, 1'b0);
        chk("seq_err", 32'(seq_err_count), 32'd1);

        // Asynchronous reset in the middle of a cycle.
        apply_reset();
        out_ready = 1'b0;
        for (int i = 1; i <= 6; i++) tick(1'b1, 8'(i), 1'b0);
        chk("mid_pre_valid", 32'(out_valid), 32'h1);
        #2;
        rst = 1'b1;
        #1;
        chk_zero_outputs("mid_rst");
        model_clear();
        #1;
        rst = 1'b0;
        @(negedge clk);
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) tick(1'b1, 8'(8'h31 + i), 1'b0);
        chk("mid_word", out_data, 32'h34333231);
        chk("mid_keep", 32'(out_keep), 32'hF);
        tick(1'b0, 8'h00, 1'b0);
        chk("mid_wc", 32'(word_count), 32'd1);
        chk("mid_sec", 32'(seq_err_count), 32'd0);

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/byte_packer.md
# byte_packer

Downstream stage of the source → FIFO → sink chain. Accepts the sink's captured byte stream (`captured_data_valid` / `captured_data`) and packs bytes little-endian into `LANES`-byte words. Completed words go through a small output buffer with a valid/ready handshake. Because the input has no backpressure, the block also counts increment-sequence errors and flags dropped words.

## Interface
Parameters:
- `LANES`, 4: bytes per output word; must be a power of 2, ≥ 2.
- `OBUF_DEPTH`, 2: output buffer entries; ≥ 1.

Ports:
- `clk`  in  1  sole clock; all logic on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  byte strobe; connects to sink `captured_data_valid`.
- `in_data`  in  8  byte value; connects to sink `captured_data`.
- `flush`  in  1  single-cycle request to emit a partial word.
- `out_valid`  out  1  head of output buffer valid.
- `out_ready`  in  1  consumer accepts head word when high with `out_valid`.
- `out_data`  out  8*LANES  packed word; first byte in bits [7:0].
- `out_keep`  out  LANES  per-byte valid mask of head word.
- `overflow`  out  1  sticky; a word was dropped because the buffer was full.
- `word_count`  out  16  words handed off (`out_valid & out_ready`); wraps at 2^16.
- `seq_err_count`  out  16  sequence violations; saturates at 16'hFFFF.

## Operation
- **Reset values:** all outputs 0; lane counter 0; buffer empty; sequence reference invalid.
- **Assembly FSM:**
  - EMPTY: lane count 0.
  - FILL: lane count 1..LANES-1.
  - Each `in_valid` writes `in_data` into the lane at the current lane count, then increments it.
  - When the byte fills lane LANES-1, the word completes with keep all-ones, and the FSM returns to EMPTY in the same edge.
- **Flush:**
  - `flush` in FILL completes the partial word. `out_keep` has ones in lanes 0..n-1. Unused lanes of `out_data` are 0. FSM returns to EMPTY.
  - `flush` together with `in_valid`: the byte is written first, then the word is flushed. If that byte already fills the word, the result is one full word, not two.
  - `flush` in EMPTY with no `in_valid`: no-op.
- **Output buffer:**
  - FIFO of `OBUF_DEPTH` entries, each holding {data, keep}.
  - A completed word is pushed if there is space. Space counts a same-cycle pop: if the buffer is full and `out_valid & out_ready`, the push is accepted.
  - Otherwise the word is discarded and `overflow` is set. `overflow` is cleared only by reset.
- **Handshake:**
  - `out_valid` = buffer non-empty.
  - `out_data` / `out_keep` stay stable while `out_valid & !out_ready`.
  - Pop on `out_valid & out_ready`.
- **Sequence check:**
  - The first accepted byte after reset loads the reference and is never an error.
  - Each later byte is compared against reference + 1 mod 256. On mismatch, `seq_err_count` increments (saturating).
  - The reference always reloads with the received byte, so one glitch counts once.
  - 8'hFF → 8'h00 is legal.
- **Reset mid-operation:** a partial word, buffered words, counters and `overflow` are all lost immediately (asynchronous).

## Timing
- The byte completing a word is sampled at edge t. `out_valid` rises after edge t when the buffer was empty, so the word is visible in cycle t+1. Latency from last byte to output is 1 cycle.
- Full throughput: one byte per cycle sustained, i.e. one word per LANES cycles. With `out_ready` held high, the buffer never overflows.
- `word_count` and `seq_err_count` update at the edge where the event is sampled, visible in the next cycle.
- `overflow` asserts in the cycle after the dropped word's completion edge.

## Test plan
- **Packing:** reset, then drive bytes 0x01..0x08 on consecutive cycles with `out_ready`=1 → two words 0x04030201 and 0x08070605, keep 4'hF, `word_count`=2, `seq_err_count`=0.
- **Flush partial:** drive 0x10, 0x11, 0x12, then `flush` → word 0x00121110, keep 4'b0111. A further `flush` with no data produces no word.
- **Flush with last byte:** bytes 0x20..0x22, then 0x23 together with `flush` → exactly one word 0x23222120, keep 4'hF.
- **Overflow and backpressure:** `out_ready`=0, stream 0x01..0x0C → two words held stable, third dropped, `overflow`=1. Raise `out_ready` → 0x04030201 then 0x08070605 delivered, `word_count`=2.
- **Sequence check:** bytes 0xFE, 0xFF, 0x00, 0x05, 0x06 → `seq_err_count`=1. Wrap 0xFF→0x00 is not an error.
- **Mid-operation reset:** pulse `rst` asynchronously (not edge-aligned) after 2 bytes with a word buffered → all outputs 0 immediately. Next 4 bytes 0x31..0x34 yield the single word 0x34333231 with no sequence error.
